// File: rtl/iir_sched_pkg.sv
// Shared types and constants for the time-multiplexed biquad scheduler:
// FSM states, coefficient addresses, reset coefficients and the scaled product.
package iir_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL_G1,
        ST_MUL_G2,
        ST_MUL_G4,
        ST_MUL_G3,
        ST_DONE
    } sched_state_t;

    localparam logic [1:0] COEF_G1 = 2'd0;
    localparam logic [1:0] COEF_G2 = 2'd1;
    localparam logic [1:0] COEF_G3 = 2'd2;
    localparam logic [1:0] COEF_G4 = 2'd3;

    localparam int RST_G1 = 427;
    localparam int RST_G2 = -1769;
    localparam int RST_G3 = 146;
    localparam int RST_G4 = 784;

    // Widest supported operand; callers sign-extend into it and keep the low bits.
    localparam int MAX_W = 64;

    function automatic logic signed [2*MAX_W-1:0] prod_scale(
        input logic signed [MAX_W-1:0] a,
        input logic signed [MAX_W-1:0] b,
        input int                      sh
    );
        logic signed [2*MAX_W-1:0] full;
        full = (2*MAX_W)'(a) * (2*MAX_W)'(b);
        return full >>> sh;
    endfunction

endpackage

// File: rtl/iir_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr (with wrap)
// wins; produces a one-hot grant and its index.
module iir_rr_arbiter #(
    parameter int NCH = 4,
    parameter int CHW = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] ptr,
    output logic [NCH-1:0] grant,
    output logic [CHW-1:0] grant_idx
);

    int             idx_i;
    logic [CHW-1:0] idx;

    // NOTE: every output gets a default before the search loop so no path
    // leaves a value held over from a previous evaluation (which would infer a latch).
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx_i     = 0;
        idx       = '0;
        // Scan farthest-first so the nearest requester after ptr overwrites the rest.
        for (int off = NCH; off >= 1; off--) begin
            idx_i = (int'(ptr) + off) % NCH;
            idx   = CHW'(idx_i);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/iir_biquad_sched.sv
// Scheduler/controller for one shared biquad datapath serving NCH channels.
// Optional macro IIR_SCHED_SAT_EN: saturating x3/out arithmetic plus sat_flag output.
module iir_biquad_sched
    import iir_sched_pkg::*;
#(
    parameter int BIT_NO = 32,
    parameter int CK     = 11,
    parameter int NCH    = 4,
    parameter int CHW    = $clog2(NCH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NCH-1:0]           in_valid,
    output logic [NCH-1:0]           in_ready,
    input  logic [NCH*BIT_NO-1:0]    in_data,
    output logic                     out_valid,
    output logic [CHW-1:0]           out_ch,
    output logic signed [BIT_NO-1:0] out_data,
    input  logic                     cfg_we,
    input  logic [1:0]               cfg_addr,
    input  logic [BIT_NO-1:0]        cfg_data,
    input  logic                     cfg_commit,
    output logic                     busy,
`ifdef IIR_SCHED_SAT_EN
    output logic                     sat_flag,
`endif
    output logic                     commit_pending
);

    typedef logic signed [BIT_NO-1:0] word_t;

    localparam word_t RST_COEF [4] = '{word_t'(RST_G1), word_t'(RST_G2),
                                       word_t'(RST_G3), word_t'(RST_G4)};

    sched_state_t   state_q, state_d;
    logic [CHW-1:0] ptr_q;
    word_t          samp_q, d1_q, d2_q;
    word_t          x1_q, x6_q, x7_q, x5_q;
    word_t          d1_mem [NCH];
    word_t          d2_mem [NCH];
    word_t          act_q [4];
    word_t          shd_q [4];
    word_t          shd_d [4];
    logic           pending_q;

    logic [NCH-1:0] grant;
    logic [CHW-1:0] grant_idx;
    logic           take;
    logic           apply;
    word_t          mul_a, mul_b, mul_p;
    word_t          x3, y;

    iir_rr_arbiter #(.NCH(NCH), .CHW(CHW)) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Gated by reset as well so no grant is offered while the block is held in reset.
    assign in_ready       = (state_q == ST_IDLE && reset) ? grant : '0;
    assign take           = |(in_valid & in_ready);
    assign apply          = (state_q == ST_IDLE) && pending_q;
    assign busy           = (state_q != ST_IDLE);
    assign commit_pending = pending_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (take) state_d = ST_MUL_G1;
            ST_MUL_G1: state_d = ST_MUL_G2;
            ST_MUL_G2: state_d = ST_MUL_G4;
            ST_MUL_G4: state_d = ST_MUL_G3;
            ST_MUL_G3: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Single shared multiplier; operands steered by the current MUL state.
    always_comb begin
        mul_a = samp_q;
        mul_b = act_q[COEF_G1];
        case (state_q)
            ST_MUL_G2: begin mul_a = d1_q; mul_b = act_q[COEF_G2]; end
            ST_MUL_G4: begin mul_a = d2_q; mul_b = act_q[COEF_G4]; end
            ST_MUL_G3: begin mul_a = d1_q; mul_b = act_q[COEF_G3]; end
            default:   ;
        endcase
        mul_p = word_t'(prod_scale(MAX_W'(mul_a), MAX_W'(mul_b), CK - 1));
    end

    // Shadow-next includes this cycle's write so a same-cycle commit carries it.
    always_comb begin
        shd_d = shd_q;
        if (cfg_we) shd_d[cfg_addr] = cfg_data;
    end

`ifdef IIR_SCHED_SAT_EN
    localparam int EW = BIT_NO + 2;
    typedef logic signed [EW-1:0] wide_t;
    localparam wide_t SAT_HI = wide_t'((64'sd1 <<< (BIT_NO - 1)) - 64'sd1);
    localparam wide_t SAT_LO = wide_t'(-(64'sd1 <<< (BIT_NO - 1)));

    function automatic word_t clamp(input wide_t v);
        if (v > SAT_HI) return word_t'(SAT_HI);
        if (v < SAT_LO) return word_t'(SAT_LO);
        return word_t'(v);
    endfunction

    wide_t x3_w, y_w;
    logic  clip;

    always_comb begin
        x3_w = EW'(x1_q) - EW'(x6_q) - EW'(x7_q);
        x3   = clamp(x3_w);
        y_w  = EW'(x3) + EW'(x5_q) + EW'(d2_q);
        y    = clamp(y_w);
        clip = (EW'(x3) != x3_w) || (EW'(y) != y_w);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sat_flag <= 1'b0;
        else        sat_flag <= (state_q == ST_DONE) && clip;
    end
`else
    always_comb begin
        x3 = x1_q - x6_q - x7_q;
        y  = x3 + x5_q + d2_q;
    end
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= CHW'(NCH - 1);
            samp_q    <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            x1_q      <= '0;
            x6_q      <= '0;
            x7_q      <= '0;
            x5_q      <= '0;
            pending_q <= 1'b0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            // NOTE: the channel state arrays are reset because filter history must
            // restart from zero; they are small flop arrays, not RAM macros.
            for (int i = 0; i < NCH; i++) begin
                d1_mem[i] <= '0;
                d2_mem[i] <= '0;
            end
            for (int k = 0; k < 4; k++) begin
                act_q[k] <= RST_COEF[k];
                shd_q[k] <= RST_COEF[k];
            end
        end else begin
            state_q   <= state_d;
            shd_q     <= shd_d;
            pending_q <= cfg_commit | (pending_q & ~apply);
            if (apply) act_q <= shd_d;
            out_valid <= (state_q == ST_DONE);
            case (state_q)
                ST_IDLE: if (take) begin
                    ptr_q  <= grant_idx;
                    samp_q <= in_data[int'(grant_idx)*BIT_NO +: BIT_NO];
                    d1_q   <= d1_mem[grant_idx];
                    d2_q   <= d2_mem[grant_idx];
                end
                ST_MUL_G1: x1_q <= mul_p;
                ST_MUL_G2: x6_q <= mul_p;
                ST_MUL_G4: x7_q <= mul_p;
                ST_MUL_G3: x5_q <= mul_p;
                ST_DONE: begin
                    d1_mem[ptr_q] <= x3;
                    d2_mem[ptr_q] <= d1_q;
                    out_data      <= y;
                    out_ch        <= ptr_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_biquad_sched.sv
// Self-checking bench for iir_biquad_sched: directed vector table plus
// hand-written sequences for commit timing, async reset and round-robin order.
`timescale 1ns/1ps
module tb_iir_biquad_sched;

    localparam int BIT_NO = 32;
    localparam int CK     = 11;
    localparam int NCH    = 4;
    localparam int CHW    = 2;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic [NCH-1:0]           in_valid = '0;
    logic [NCH-1:0]           in_ready;
    logic [NCH*BIT_NO-1:0]    in_data = '0;
    logic                     out_valid;
    logic [CHW-1:0]           out_ch;
    logic signed [BIT_NO-1:0] out_data;
    logic                     cfg_we = 1'b0;
    logic [1:0]               cfg_addr = '0;
    logic [BIT_NO-1:0]        cfg_data = '0;
    logic                     cfg_commit = 1'b0;
    logic                     busy;
    logic                     commit_pending;
`ifdef IIR_SCHED_SAT_EN
    logic                     sat_flag;
`endif

    iir_biquad_sched #(.BIT_NO(BIT_NO), .CK(CK), .NCH(NCH)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ch         (out_ch),
        .out_data       (out_data),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .cfg_commit     (cfg_commit),
        .busy           (busy),
`ifdef IIR_SCHED_SAT_EN
        .sat_flag       (sat_flag),
`endif
        .commit_pending (commit_pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        in_valid   = '0;
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Present one sample on ch and return the cycle number of the accept cycle.
    task automatic send(input int ch, input logic [BIT_NO-1:0] x, output int acc_cyc);
        int budget;
        budget = 0;
        @(negedge clk);
        in_data[ch*BIT_NO +: BIT_NO] = x;
        in_valid[ch] = 1'b1;
        #1;
        while (!in_ready[ch] && budget < 20) begin
            @(negedge clk);
            #1;
            budget++;
        end
        check($sformatf("accept ch%0d", ch), in_ready[ch], 1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid[ch] = 1'b0;
    endtask

    task automatic wait_out(output logic [BIT_NO-1:0] y, output int ych, output int ycyc,
                            output logic ysat);
        int budget;
        budget = 0;
        @(negedge clk);
        while (!out_valid && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("out_valid seen", out_valid, 1);
        y    = out_data;
        ych  = int'(out_ch);
        ycyc = cyc;
`ifdef IIR_SCHED_SAT_EN
        ysat = sat_flag;
`else
        ysat = 1'b0;
`endif
    endtask

    // Reference model for the g1=32767 run on one channel.
    logic signed [31:0] md1 = 0, md2 = 0;
    logic signed [31:0] mg1 = 32767, mg2 = -1769, mg3 = 146, mg4 = 784;

    function automatic logic signed [31:0] pmul(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
        longint full;
        full = longint'(a) * longint'(b);
        full = full >>> (CK - 1);
        return full[31:0];
    endfunction

    function automatic logic signed [31:0] sat32(input longint v, output logic c);
        c = 1'b0;
        if (v > 64'sd2147483647) begin c = 1'b1; return 32'sh7FFFFFFF; end
        if (v < -64'sd2147483648) begin c = 1'b1; return 32'sh80000000; end
        return v[31:0];
    endfunction

    task automatic model_step(input logic signed [31:0] x, output logic signed [31:0] y,
                              output logic clip);
        logic signed [31:0] x1, x6, x7, x5, x3;
        logic c1, c2;
        x1 = pmul(x, mg1);
        x6 = pmul(md1, mg2);
        x7 = pmul(md2, mg4);
        x5 = pmul(md1, mg3);
`ifdef IIR_SCHED_SAT_EN
        x3   = sat32(longint'(x1) - longint'(x6) - longint'(x7), c1);
        y    = sat32(longint'(x3) + longint'(x5) + longint'(md2), c2);
        clip = c1 | c2;
`else
        c1   = 1'b0;
        c2   = 1'b0;
        x3   = x1 - x6 - x7;
        y    = x3 + x5 + md2;
        clip = c1 | c2;
`endif
        md2 = md1;
        md1 = x3;
    endtask

    typedef struct {
        int          ch;
        logic [31:0] din;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          acc, ocyc, och, ng, viol, nov;
        logic [31:0] y, ym;
        logic        ys, clip;
        int          g_idx [5];
        int          g_cyc [5];
        logic [31:0] sat_in [4];

        vecs[0] = '{ch: 0, din: 32'd1024, dout: 32'd427};
        vecs[1] = '{ch: 0, din: 32'd0,    dout: 32'd798};
        vecs[2] = '{ch: 1, din: 32'd1024, dout: 32'd427};
        vecs[3] = '{ch: 0, din: 32'd0,    dout: 32'd1481};
        vecs[4] = '{ch: 1, din: 32'd0,    dout: 32'd798};

        // Reset state
        @(negedge clk);
        check("rst in_ready", in_ready, 0);
        check("rst out_valid", out_valid, 0);
        check("rst out_ch", out_ch, 0);
        check("rst out_data", out_data, 0);
        check("rst busy", busy, 0);
        check("rst commit_pending", commit_pending, 0);
        reset = 1'b1;

        // Impulse response and channel isolation
        foreach (vecs[i]) begin
            send(vecs[i].ch, vecs[i].din, acc);
            wait_out(y, och, ocyc, ys);
            check($sformatf("vec%0d out_data", i), y, vecs[i].dout);
            check($sformatf("vec%0d out_ch", i), och, vecs[i].ch);
            check($sformatf("vec%0d latency", i), ocyc - acc, 6);
        end

        // Commit while busy: in-flight sample keeps the old set
        do_reset();
        send(0, 32'd1024, acc);
        @(negedge clk);
        @(negedge clk);
        check("commit in MUL_G2 busy", busy, 1);
        cfg_we     = 1'b1;
        cfg_addr   = 2'd0;
        cfg_data   = 32'd1024;
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
        check("pending after commit", commit_pending, 1);
        @(negedge clk);
        @(negedge clk);
        check("pending in DONE", commit_pending, 1);
        @(negedge clk);
        check("old-set out_valid", out_valid, 1);
        check("old-set out_data", out_data, 427);
        check("pending in IDLE", commit_pending, 1);
        @(negedge clk);
        check("pending cleared", commit_pending, 0);
        send(2, 32'd1024, acc);
        wait_out(y, och, ocyc, ys);
        check("new-set out_data", y, 1024);
        check("new-set out_ch", och, 2);

        // Async reset during MUL_G4 drops the sample and clears state
        send(0, 32'd1024, acc);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #10;
        @(negedge clk);
        reset = 1'b1;
        nov = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) nov++;
        end
        check("no out_valid after abort", nov, 0);
        in_data[0*BIT_NO +: BIT_NO] = 32'd1024;
        in_data[1*BIT_NO +: BIT_NO] = 32'd1024;
        in_valid = 4'b0011;
        #1;
        check("restart grant ch0", in_ready, 4'b0001);
        @(posedge clk);
        #1;
        in_valid = '0;
        wait_out(y, och, ocyc, ys);
        check("post-reset out_data", y, 427);
        check("post-reset out_ch", och, 0);

        // Round-robin with all requests held from reset
        in_data = '0;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 4'b1111;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ng    = 0;
        viol  = 0;
        for (int k = 0; k < 5; k++) begin
            g_idx[k] = -1;
            g_cyc[k] = -1000;
        end
        for (int k = 0; k < 40 && ng < 5; k++) begin
            #1;
            if (in_ready != '0) begin
                if (busy || !$onehot(in_ready)) viol++;
                g_idx[ng] = $clog2(in_ready);
                g_cyc[ng] = cyc;
                ng++;
            end
            @(negedge clk);
        end
        in_valid = '0;
        check("rr grant count", ng, 5);
        for (int k = 0; k < 5; k++)
            check($sformatf("rr grant %0d", k), g_idx[k], k % NCH);
        for (int k = 1; k < 5; k++)
            check($sformatf("rr spacing %0d", k), g_cyc[k] - g_cyc[k-1], 6);
        check("rr in_ready outside IDLE", viol, 0);
        repeat (10) @(negedge clk);

        // Large values with g1=32767, checked against the reference model
        do_reset();
        @(negedge clk);
        cfg_we     = 1'b1;
        cfg_addr   = 2'd0;
        cfg_data   = 32'd32767;
        cfg_commit = 1'b1;
        @(negedge clk);
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
        @(negedge clk);
        check("g1 commit applied", commit_pending, 0);
        sat_in[0] = 32'h7FFFFFFF;
        sat_in[1] = 32'h04000000;
        sat_in[2] = 32'h04000000;
        sat_in[3] = 32'h80000000;
        for (int k = 0; k < 4; k++) begin
            model_step(sat_in[k], ym, clip);
            send(3, sat_in[k], acc);
            wait_out(y, och, ocyc, ys);
            check($sformatf("big%0d out_data", k), y, ym);
            check($sformatf("big%0d out_ch", k), och, 3);
`ifdef IIR_SCHED_SAT_EN
            check($sformatf("big%0d sat_flag", k), ys, clip);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
